// File: rtl/poly_pkg.sv
// Shared types for the Horner polynomial evaluator.
// State encoding also drives the Y observation port.
package poly_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    MAC  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/poly_horner_ctrl_if.sv
// Start/operand/result bundle of the Horner evaluator.
// master drives start and operands; slave is the evaluator.
interface poly_horner_ctrl_if #(
  parameter int WIDTH  = 8,
  parameter int DEGREE = 3
);
  import poly_pkg::*;

  logic                        w;
  logic [WIDTH-1:0]            x;
  logic [(DEGREE+1)*WIDTH-1:0] coef;
  logic [WIDTH-1:0]            result;
  logic                        done;
  logic                        busy;
  logic                        ovf;
  logic [STATE_W-1:0]          Y;

  modport master (
    output w, x, coef,
    input  result, done, busy, ovf, Y
  );

  modport slave (
    input  w, x, coef,
    output result, done, busy, ovf, Y
  );

endinterface

// File: rtl/poly_mac_step.sv
// One Horner step: y = reduce(s*x + a), full precision 2*WIDTH+1.
// POLY_SAT_EN selects saturation; otherwise low WIDTH bits kept.
module poly_mac_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] s_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] a_i,
  output logic [WIDTH-1:0] y_o,
  output logic             ovf_o
);

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH:0]   sum;
  logic               hi;

  assign prod = {{WIDTH{1'b0}}, s_i} * {{WIDTH{1'b0}}, x_i};
  assign sum  = {1'b0, prod} + {{(WIDTH+1){1'b0}}, a_i};
  assign hi   = |sum[2*WIDTH:WIDTH];

`ifdef POLY_SAT_EN
  assign y_o   = hi ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
  assign ovf_o = hi;
`else
  logic unused_hi;
  assign unused_hi = hi;
  assign y_o       = sum[WIDTH-1:0];
  assign ovf_o     = 1'b0;
`endif

endmodule

// File: rtl/poly_horner_ctrl.sv
// Horner evaluator: FSM, operand capture, accumulator, result.
// Optional saturating reduction via POLY_SAT_EN.
module poly_horner_ctrl
  import poly_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEGREE = 3
) (
  input logic               clk,
  input logic               rst,
  poly_horner_ctrl_if.slave bus
);

  localparam int KW = $clog2(DEGREE + 1);
  localparam int CW = (DEGREE + 1) * WIDTH;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [CW-1:0]    coef_q, coef_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] step_a;
  logic [WIDTH-1:0] step_y;
  logic             step_ovf;

  assign step_a = coef_q[int'(k_q)*WIDTH +: WIDTH];

  poly_mac_step #(.WIDTH(WIDTH)) u_step (
    .s_i   (s_q),
    .x_i   (x_q),
    .a_i   (step_a),
    .y_o   (step_y),
    .ovf_o (step_ovf)
  );

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      s_q      <= '0;
      k_q      <= '0;
      x_q      <= '0;
      coef_q   <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      k_q      <= k_d;
      x_q      <= x_d;
      coef_q   <= coef_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state and datapath updates; hold everything by default.
  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    k_d      = k_q;
    x_d      = x_q;
    coef_d   = coef_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.w) begin
          x_d     = bus.x;
          coef_d  = bus.coef;
          state_d = LOAD;
        end
      end
      LOAD: begin
        s_d     = coef_q[DEGREE*WIDTH +: WIDTH];
        k_d     = KW'(DEGREE - 1);
        ovf_d   = 1'b0;
        state_d = MAC;
      end
      MAC: begin
        s_d   = step_y;
        ovf_d = ovf_q | step_ovf;
        if (k_q == '0) begin
          result_d = step_y;
          state_d  = DONE;
        end else begin
          k_d = k_q - KW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.result = result_q;
  assign bus.done   = (state_q == DONE);
  assign bus.busy   = (state_q != IDLE);
  assign bus.ovf    = ovf_q;
  assign bus.Y      = state_q;

endmodule

// File: tb/tb_poly_horner_ctrl.sv
// Directed bench for poly_horner_ctrl, D=3 and D=1 instances.
// Horner reference model fills a queue; done pulses pop it.
module tb_poly_horner_ctrl;
  import poly_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  poly_horner_ctrl_if #(.WIDTH(W), .DEGREE(3)) b3();
  poly_horner_ctrl_if #(.WIDTH(W), .DEGREE(1)) b1();

  poly_horner_ctrl #(.WIDTH(W), .DEGREE(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (b3)
  );

  poly_horner_ctrl #(.WIDTH(W), .DEGREE(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  typedef struct {
    logic [W-1:0] r;
    logic         o;
  } exp_t;

  exp_t q3[$];
  exp_t q1[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done3_n = 0;
  int done1_n = 0;
  int last3 = 0;
  int last1 = 0;
  int busy3_n = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] model(input int deg,
                                       input logic [4*W-1:0] c,
                                       input logic [W-1:0] xv);
    logic [2*W:0] t;
    logic [W-1:0] s;
    logic o;
    s = c[deg*W +: W];
    o = 1'b0;
    for (int i = deg - 1; i >= 0; i--) begin
      t = (2*W+1)'(s) * (2*W+1)'(xv) + (2*W+1)'(c[i*W +: W]);
`ifdef POLY_SAT_EN
      if (|t[2*W:W]) begin
        s = '1;
        o = 1'b1;
      end else begin
        s = t[W-1:0];
      end
`else
      s = t[W-1:0];
`endif
    end
    return {o, s};
  endfunction

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (b3.busy) busy3_n++;
    if (b3.done) begin
      done3_n++;
      last3 = cyc;
      chk("d3_pending", 32'(q3.size() > 0), 1);
      if (q3.size() > 0) begin
        e = q3.pop_front();
        chk("d3_result", 32'(b3.result), 32'(e.r));
        chk("d3_ovf", 32'(b3.ovf), 32'(e.o));
      end
    end
    if (b1.done) begin
      done1_n++;
      last1 = cyc;
      chk("d1_pending", 32'(q1.size() > 0), 1);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("d1_result", 32'(b1.result), 32'(e.r));
        chk("d1_ovf", 32'(b1.ovf), 32'(e.o));
      end
    end
  endtask

  task automatic push3(input logic [31:0] c, input logic [W-1:0] xv);
    logic [W:0] m;
    m = model(3, c, xv);
    q3.push_back('{m[W-1:0], m[W]});
  endtask

  task automatic push1(input logic [15:0] c, input logic [W-1:0] xv);
    logic [W:0] m;
    m = model(1, {16'd0, c}, xv);
    q1.push_back('{m[W-1:0], m[W]});
  endtask

  task automatic start3(input logic [31:0] c, input logic [W-1:0] xv,
                        output int s);
    b3.coef = c;
    b3.x = xv;
    b3.w = 1'b1;
    push3(c, xv);
    tick();
    s = cyc;
    b3.w = 1'b0;
    b3.x = W'($urandom);
    b3.coef = $urandom;
  endtask

  task automatic wait3(input int target, input string tag);
    for (int i = 0; i < 20 && done3_n < target; i++) tick();
    chk(tag, 32'(done3_n >= target), 1);
  endtask

  localparam logic [31:0] C1234 = {8'd1, 8'd2, 8'd3, 8'd4};

  initial begin
    int s;
    int d_first;
    int n0;
    rst = 1'b1;
    b3.w = 1'b0;
    b3.x = '0;
    b3.coef = '0;
    b1.w = 1'b0;
    b1.x = '0;
    b1.coef = '0;
    repeat (3) tick();
    chk("rst_Y", 32'(b3.Y), 0);
    chk("rst_busy", 32'(b3.busy), 0);
    chk("rst_done", 32'(b3.done), 0);
    chk("rst_result", 32'(b3.result), 0);
    chk("rst_ovf", 32'(b3.ovf), 0);
    chk("rst_result1", 32'(b1.result), 0);
    rst = 1'b0;
    tick();

    busy3_n = 0;
    n0 = done3_n;
    start3(C1234, 8'd2, s);
    chk("load_Y", 32'(b3.Y), 32'(LOAD));
    wait3(n0 + 1, "x2_timeout");
    chk("x2_latency", 32'(last3 - s), 4);
    chk("x2_result", 32'(b3.result), 26);
    repeat (4) tick();
    chk("x2_single_done", 32'(done3_n), 32'(n0 + 1));
    chk("x2_busy_cycles", 32'(busy3_n), 5);
    chk("x2_result_held", 32'(b3.result), 26);

    n0 = done3_n;
    start3(C1234, 8'd10, s);
    wait3(n0 + 1, "x10_timeout");
`ifdef POLY_SAT_EN
    chk("x10_result", 32'(b3.result), 255);
    chk("x10_ovf", 32'(b3.ovf), 1);
`else
    chk("x10_result", 32'(b3.result), 210);
    chk("x10_ovf", 32'(b3.ovf), 0);
`endif
    tick();

    n0 = done3_n;
    start3(C1234, 8'd2, s);
    tick();
    b3.w = 1'b1;
    b3.x = 8'd5;
    tick();
    b3.w = 1'b0;
    wait3(n0 + 1, "ign_timeout");
    repeat (6) tick();
    chk("ign_single_done", 32'(done3_n), 32'(n0 + 1));
    chk("ign_result", 32'(b3.result), 26);
    chk("ign_queue_empty", 32'(q3.size()), 0);

    n0 = done3_n;
    start3(C1234, 8'd3, s);
    wait3(n0 + 1, "x3_timeout");
    tick();

    n0 = done3_n;
    start3({8'd9, 8'd9, 8'd9, 8'd9}, 8'd7, s);
    tick();
    tick();
    chk("pre_rst_Y", 32'(b3.Y), 32'(MAC));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q3.delete();
    chk("mrst_Y", 32'(b3.Y), 0);
    chk("mrst_busy", 32'(b3.busy), 0);
    chk("mrst_result", 32'(b3.result), 0);
    repeat (8) tick();
    chk("mrst_no_done", 32'(done3_n), 32'(n0));

    n0 = done3_n;
    b3.coef = C1234;
    b3.x = 8'd2;
    b3.w = 1'b1;
    push3(C1234, 8'd2);
    tick();
    b3.x = 8'd1;
    push3(C1234, 8'd1);
    d_first = 0;
    for (int i = 0; i < 20 && done3_n < n0 + 2; i++) begin
      tick();
      if (done3_n == n0 + 1 && d_first == 0) d_first = last3;
    end
    b3.w = 1'b0;
    chk("held_two_done", 32'(done3_n), 32'(n0 + 2));
    chk("held_interval", 32'(last3 - d_first), 6);
    chk("held_result", 32'(b3.result), 10);
    repeat (4) tick();
    chk("held_queue_empty", 32'(q3.size()), 0);

    n0 = done1_n;
    b1.coef = {8'd5, 8'd7};
    b1.x = 8'd3;
    b1.w = 1'b1;
    push1({8'd5, 8'd7}, 8'd3);
    tick();
    s = cyc;
    b1.w = 1'b0;
    b1.x = 8'd0;
    for (int i = 0; i < 10 && done1_n < n0 + 1; i++) tick();
    chk("d1_done_seen", 32'(done1_n), 32'(n0 + 1));
    chk("d1_latency", 32'(last1 - s), 2);
    chk("d1_result22", 32'(b1.result), 22);
    tick();

    n0 = done1_n;
    b1.coef = 16'hFFFF;
    b1.x = 8'hFF;
    b1.w = 1'b1;
    push1(16'hFFFF, 8'hFF);
    tick();
    b1.w = 1'b0;
    for (int i = 0; i < 10 && done1_n < n0 + 1; i++) tick();
    chk("d1_max_done", 32'(done1_n), 32'(n0 + 1));
    repeat (3) tick();
    chk("d1_queue_empty", 32'(q1.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
